// File: rtl/aes_decrypt_seq.sv
// Iterative AES-128 decryption core: one inverse round per clock, with the
// key schedule unrolled backwards on the fly from the round-10 key.
module aes_decrypt_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] ciphertext,
  input  logic [127:0] key_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_reg;
  logic [127:0] st_reg;
  logic [127:0] rk_reg;
  logic [127:0] plaintext_reg;
  logic [3:0]   rnd_reg;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  p0, p1, p2, p3;
  logic [31:0]  rot_p3, sub_p3;
  logic [127:0] rk_prev;
  logic [127:0] sub_next;
  logic [127:0] mix_next;

  // GF(2^8) multiply, reduction polynomial 0x11b
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = gf_mul(a, a);              // a^2
    t = gf_mul(t, a);              // a^3
    t = gf_mul(gf_mul(t, t), a);   // a^7
    t = gf_mul(gf_mul(t, t), a);   // a^15
    t = gf_mul(gf_mul(t, t), a);   // a^31
    t = gf_mul(gf_mul(t, t), a);   // a^63
    t = gf_mul(gf_mul(t, t), a);   // a^127
    return gf_mul(t, t);           // a^254
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
    logic [15:0] d;
    d = {a, a} << n;
    return d[15:8];
  endfunction

  // Forward S-box: inverse followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = gf_inv(a);
    return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
  endfunction

  // Inverse S-box: inverse affine transform followed by the inverse
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  // Step the key schedule back one round: rk_reg holds round rnd, rk_prev is round rnd-1
  assign {w0, w1, w2, w3} = rk_reg;
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;
  assign rot_p3 = {p3[23:0], p3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      assign sub_p3[8*gi +: 8] = sbox(rot_p3[8*gi +: 8]);
    end
  endgenerate

  assign p0      = w0 ^ sub_p3 ^ {rcon(rnd_reg), 24'h000000};
  assign rk_prev = {p0, p1, p2, p3};

  // InvShiftRows folded into the byte select, then InvSubBytes and AddRoundKey.
  // Byte index gi = 4*col + row; row r rotates right by r columns.
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bytes
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
      assign sub_next[127-8*gi -: 8] = inv_sbox(st_reg[127-8*SRC -: 8]) ^ rk_prev[127-8*gi -: 8];
    end
    for (gi = 0; gi < 4; gi++) begin : g_cols
      assign mix_next[127-32*gi -: 32] = inv_mix_col(sub_next[127-32*gi -: 32]);
    end
  endgenerate

  // Control FSM and datapath registers; the last round skips InvMixColumns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      st_reg        <= '0;
      rk_reg        <= '0;
      rnd_reg       <= '0;
      plaintext_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            st_reg    <= ciphertext ^ key_last;
            rk_reg    <= key_last;
            rnd_reg   <= 4'd10;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          rk_reg  <= rk_prev;
          rnd_reg <= rnd_reg - 4'd1;
          if (rnd_reg == 4'd1) begin
            st_reg        <= sub_next;
            plaintext_reg <= sub_next;
            state_reg     <= DONE;
          end else begin
            st_reg <= mix_next;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == ROUND);
  assign plaintext = plaintext_reg;

endmodule

// File: tb/tb_aes_decrypt_seq.sv
// Directed bench for aes_decrypt_seq using FIPS-197 known-answer vectors.
module tb_aes_decrypt_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ciphertext;
  logic [127:0] key_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n;

  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_C1  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] K_B   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_decrypt_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ciphertext (ciphertext),
    .key_last   (key_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .plaintext  (plaintext),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Status bits packed as {out_valid, in_ready, busy}
  task automatic check_flags(input string tag, input logic [2:0] exp);
    check(tag, {125'd0, out_valid, in_ready, busy}, {125'd0, exp});
  endtask

  // Count edges until out_valid, bounded so a stuck DUT cannot hang the run
  task automatic wait_out(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 30) begin
      step();
      cnt++;
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ciphertext = '0;
    key_last   = '0;

    // Reset state
    #2;
    check_flags("reset_flags", 3'b010);
    check("reset_pt", plaintext, 128'd0);
    step();
    step();
    rst = 1'b0;
    out_ready = 1'b1;  // no effect in IDLE
    step();
    check_flags("idle_flags", 3'b010);

    // FIPS-197 C.1
    ciphertext = CT_C1; key_last = K_C1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; ciphertext = CT_B; key_last = K_B;
    check_flags("c1_after_accept", 3'b001);
    wait_out(n);
    check("c1_latency", n, 10);
    check("c1_pt", plaintext, PT_C1);
    step();
    check_flags("c1_one_cycle", 3'b010);
    check("c1_retained", plaintext, PT_C1);
    display_txn("C.1", PT_C1);

    // FIPS-197 B with backpressure
    out_ready = 1'b0;
    ciphertext = CT_B; key_last = K_B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    wait_out(n);
    check("b_latency", n, 10);
    check("b_pt", plaintext, PT_B);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_pt_stable", plaintext, PT_B);
      check_flags("bp_flags", 3'b100);
    end
    out_ready = 1'b1;
    step();
    check_flags("bp_release", 3'b010);
    display_txn("B backpressure", PT_B);

    // Busy-ignore: in_valid toggles with a different block during ROUND
    ciphertext = CT_C1; key_last = K_C1; in_valid = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      ciphertext = CT_B; key_last = K_B;
      in_valid = ~in_valid;
      step();
    end
    in_valid = 1'b0;
    wait_out(n);
    check("ign_latency", n, 4);
    check("ign_pt", plaintext, PT_C1);
    step();
    step();
    step();
    check_flags("ign_single_accept", 3'b010);
    display_txn("busy-ignore", PT_C1);

    // Reset at round 5 discards the block
    ciphertext = CT_C1; key_last = K_C1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check_flags("pre_reset_busy", 3'b001);
    rst = 1'b1;
    #1;
    check_flags("rst_async_flags", 3'b010);
    check("rst_async_pt", plaintext, 128'd0);
    step();
    check_flags("rst_hold_flags", 3'b010);
    ciphertext = CT_B; key_last = K_B; in_valid = 1'b1;
    rst = 1'b0;
    step();
    in_valid = 1'b0;
    check_flags("post_rst_accept", 3'b001);
    wait_out(n);
    check("post_rst_latency", n, 10);
    check("post_rst_pt", plaintext, PT_B);
    step();
    display_txn("reset mid-op then B", PT_B);

    // Back-to-back with in_valid held high
    ciphertext = CT_C1; key_last = K_C1; in_valid = 1'b1;
    step();
    ciphertext = CT_B; key_last = K_B;
    wait_out(n);
    check("b2b_first_latency", n, 10);
    check("b2b_first_pt", plaintext, PT_C1);
    step();
    check_flags("b2b_idle_gap", 3'b010);
    step();
    in_valid = 1'b0;
    check_flags("b2b_second_accept", 3'b001);
    wait_out(n);
    check("b2b_second_latency", n, 10);
    check("b2b_second_pt", plaintext, PT_B);
    step();
    check_flags("b2b_end", 3'b010);
    display_txn("back-to-back", PT_B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic display_txn(input string name, input logic [127:0] exp);
    $display("txn %s: plaintext=%h expected=%h", name, plaintext, exp);
  endtask

endmodule
